// File: rtl/cmd_proto_pkg.sv
// rtl/cmd_proto_pkg.sv - command characters and command classes of the serial test protocol
package cmd_proto_pkg;

    localparam logic [7:0] CMD_R   = 8'h72;
    localparam logic [7:0] CMD_S   = 8'h73;
    localparam logic [7:0] CMD_G   = 8'h67;
    localparam logic [7:0] CMD_I   = 8'h69;
    localparam logic [7:0] CMD_O   = 8'h6F;
    localparam logic [7:0] CMD_E   = 8'h65;
    localparam logic [7:0] CMD_F   = 8'h66;
    localparam logic [7:0] CMD_P   = 8'h70;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_1 = 8'h31;

    typedef enum logic [1:0] {
        CLS_NO_ARG,
        CLS_COUNT_ONLY,
        CLS_COUNT_PAYLOAD,
        CLS_COUNT_READ
    } cmd_class_t;

    // Unknown characters fall into NO_ARG so they still go out as a lone byte.
    function automatic cmd_class_t cmd_class(input logic [7:0] cmd);
        cmd_class_t c;
        c = CLS_NO_ARG;
        case (cmd)
            CMD_E:        c = CLS_COUNT_ONLY;
            CMD_S, CMD_I: c = CLS_COUNT_PAYLOAD;
            CMD_G, CMD_O: c = CLS_COUNT_READ;
            default:      c = CLS_NO_ARG;
        endcase
        return c;
    endfunction

    function automatic logic cmd_known(input logic [7:0] cmd);
        logic k;
        k = 1'b0;
        case (cmd)
            CMD_R, CMD_S, CMD_G, CMD_I, CMD_O, CMD_E, CMD_F, CMD_P: k = 1'b1;
            default: k = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/tx_sink.sv
// rtl/tx_sink.sv - transmitter endpoint model: ready handshake plus one-cycle byte capture strobe
module tx_sink #(
    parameter int BUSY_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o
);

    logic [15:0] r_busy_cnt;
    logic        r_byte_valid;
    logic [7:0]  r_byte_data;
    logic        w_accept;

    assign tx_ready_o   = (r_busy_cnt == 16'd0);
    assign w_accept     = tx_start_i & tx_ready_o;
    assign byte_valid_o = r_byte_valid;
    assign byte_data_o  = r_byte_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cnt   <= 16'd0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= 8'd0;
        end else begin
            r_byte_valid <= w_accept;
            if (w_accept) begin
                r_busy_cnt  <= 16'(BUSY_CYCLES);
                r_byte_data <= tx_data_i;
            end else if (r_busy_cnt != 16'd0) begin
                r_busy_cnt <= r_busy_cnt - 16'd1;
            end
        end
    end

endmodule

// File: rtl/cmd_issuer.sv
// rtl/cmd_issuer.sv - serializes one test command onto the parser rx interface and collects its reply
module cmd_issuer
    import cmd_proto_pkg::*;
#(
    parameter int MAX_BITS       = 64,
    parameter int GAP_CYCLES     = 16,
    parameter int TX_BUSY_CYCLES = 8,
    parameter int RESP_TIMEOUT   = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [7:0]          req_cmd_i,
    input  logic [15:0]         req_count_i,
    input  logic [MAX_BITS-1:0] req_bits_i,
    output logic [7:0]          rx_data_o,
    output logic                new_rx_data_o,
    input  logic                tx_start_i,
    input  logic [7:0]          tx_data_i,
    output logic                tx_ready_o,
    output logic                rsp_valid_o,
    output logic [MAX_BITS-1:0] rsp_bits_o,
    output logic [15:0]         rsp_count_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o
);

    localparam int          IDX_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [15:0] MAX_CNT  = 16'(MAX_BITS);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LIMIT = 16'(RESP_TIMEOUT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEND_CMD = 3'd1;
    localparam logic [2:0] S_GAP      = 3'd2;
    localparam logic [2:0] S_SEND_HI  = 3'd3;
    localparam logic [2:0] S_SEND_LO  = 3'd4;
    localparam logic [2:0] S_SEND_BIT = 3'd5;
    localparam logic [2:0] S_WAIT_RSP = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]          r_state, r_after_gap;
    logic [15:0]         r_gap_cnt, r_count, r_expected, r_bit_idx, r_to_cnt;
    logic [7:0]          r_cmd;
    logic [MAX_BITS-1:0] r_bits, r_rsp_bits;
    cmd_class_t          r_class;
    logic                r_collect;
    logic [15:0]         r_rsp_count;
    logic                r_rsp_err, r_rsp_timeout;

    cmd_class_t  w_req_class;
    logic        w_count_bad, w_byte_valid, w_collect, w_take, w_timeout, w_rsp_done;
    logic [7:0]  w_byte_data;

    tx_sink #(.BUSY_CYCLES(TX_BUSY_CYCLES)) u_tx_sink (
        .clk          (clk),
        .rst          (rst),
        .tx_start_i   (tx_start_i),
        .tx_data_i    (tx_data_i),
        .tx_ready_o   (tx_ready_o),
        .byte_valid_o (w_byte_valid),
        .byte_data_o  (w_byte_data)
    );

    assign w_req_class = cmd_class(req_cmd_i);
    assign w_count_bad = ((w_req_class == CLS_COUNT_PAYLOAD) || (w_req_class == CLS_COUNT_READ)) &&
                         ((req_count_i == 16'd0) || (req_count_i > MAX_CNT));
    // The window opens on the command byte itself so a fast parser reply is never lost.
    assign w_collect   = (r_collect && (r_state != S_DONE)) ||
                         ((r_state == S_SEND_CMD) && (r_class == CLS_COUNT_READ));
    assign w_take      = w_collect & w_byte_valid;
    assign w_rsp_done  = (r_rsp_count >= r_expected);
    assign w_timeout   = (r_state == S_WAIT_RSP) && !w_take && (r_to_cnt >= TO_LIMIT);

    assign req_ready_o   = (r_state == S_IDLE);
    assign rsp_valid_o   = (r_state == S_DONE);
    assign rsp_bits_o    = r_rsp_bits;
    assign rsp_count_o   = r_rsp_count;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;

    always_comb begin
        rx_data_o     = 8'd0;
        new_rx_data_o = 1'b0;
        case (r_state)
            S_SEND_CMD: begin rx_data_o = r_cmd;          new_rx_data_o = 1'b1; end
            S_SEND_HI:  begin rx_data_o = r_count[15:8];  new_rx_data_o = 1'b1; end
            S_SEND_LO:  begin rx_data_o = r_count[7:0];   new_rx_data_o = 1'b1; end
            S_SEND_BIT: begin
                rx_data_o     = r_bits[r_bit_idx[IDX_W-1:0]] ? ASCII_1 : ASCII_0;
                new_rx_data_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_after_gap   <= S_IDLE;
            r_gap_cnt     <= 16'd0;
            r_count       <= 16'd0;
            r_expected    <= 16'd0;
            r_bit_idx     <= 16'd0;
            r_to_cnt      <= 16'd0;
            r_cmd         <= 8'd0;
            r_bits        <= '0;
            r_class       <= CLS_NO_ARG;
            r_collect     <= 1'b0;
            r_rsp_bits    <= '0;
            r_rsp_count   <= 16'd0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid_i) begin
                    r_cmd         <= req_cmd_i;
                    r_count       <= req_count_i;
                    r_bits        <= req_bits_i;
                    r_class       <= w_req_class;
                    r_expected    <= (req_cmd_i == CMD_O) ?
                                     ((req_count_i > 16'd1) ? req_count_i - 16'd1 : 16'd1) :
                                     req_count_i;
                    r_bit_idx     <= 16'd0;
                    r_to_cnt      <= 16'd0;
                    r_rsp_bits    <= '0;
                    r_rsp_count   <= 16'd0;
                    r_rsp_err     <= !cmd_known(req_cmd_i) || w_count_bad;
                    r_rsp_timeout <= 1'b0;
                    r_state       <= w_count_bad ? S_DONE : S_SEND_CMD;
                end
                S_SEND_CMD: begin
                    r_gap_cnt   <= 16'd0;
                    r_state     <= S_GAP;
                    r_after_gap <= (r_class == CLS_NO_ARG) ? S_DONE : S_SEND_HI;
                    if (r_class == CLS_COUNT_READ) r_collect <= 1'b1;
                end
                S_SEND_HI: begin
                    r_gap_cnt   <= 16'd0;
                    r_state     <= S_GAP;
                    r_after_gap <= S_SEND_LO;
                end
                S_SEND_LO: begin
                    r_gap_cnt   <= 16'd0;
                    r_state     <= S_GAP;
                    r_after_gap <= (r_class == CLS_COUNT_PAYLOAD) ? S_SEND_BIT :
                                   (r_class == CLS_COUNT_READ)    ? S_WAIT_RSP : S_DONE;
                end
                S_SEND_BIT: begin
                    r_gap_cnt   <= 16'd0;
                    r_bit_idx   <= r_bit_idx + 16'd1;
                    r_state     <= S_GAP;
                    r_after_gap <= ((r_bit_idx + 16'd1) >= r_count) ? S_DONE : S_SEND_BIT;
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) r_state   <= r_after_gap;
                    else                       r_gap_cnt <= r_gap_cnt + 16'd1;
                end
                S_WAIT_RSP: begin
                    if (w_rsp_done) begin
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_state       <= S_DONE;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_collect <= 1'b0;
                end
            endcase

            if (w_take) begin
                if (r_rsp_count < MAX_CNT) begin
                    r_rsp_bits[r_rsp_count[IDX_W-1:0]] <= (w_byte_data == ASCII_1);
                    r_rsp_count <= r_rsp_count + 16'd1;
                    if ((w_byte_data != ASCII_0) && (w_byte_data != ASCII_1)) r_rsp_err <= 1'b1;
                end else begin
                    r_rsp_err <= 1'b1;
                end
            end

            if (w_take)
                r_to_cnt <= 16'd0;
            else if ((r_state == S_WAIT_RSP) && (r_to_cnt != 16'hFFFF))
                r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cmd_issuer.sv
// tb/tb_cmd_issuer.sv - directed vector bench for cmd_issuer
module tb_cmd_issuer;

    localparam int MB   = 8;
    localparam int GAP  = 4;
    localparam int BUSY = 3;
    localparam int TO   = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready_o;
    logic [7:0]    req_cmd;
    logic [15:0]   req_count;
    logic [MB-1:0] req_bits;
    logic [7:0]    rx_data_o;
    logic          new_rx_data_o;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_ready_o;
    logic          rsp_valid_o;
    logic [MB-1:0] rsp_bits_o;
    logic [15:0]   rsp_count_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;

    cmd_issuer #(.MAX_BITS(MB), .GAP_CYCLES(GAP), .TX_BUSY_CYCLES(BUSY), .RESP_TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_cmd_i     (req_cmd),
        .req_count_i   (req_count),
        .req_bits_i    (req_bits),
        .rx_data_o     (rx_data_o),
        .new_rx_data_o (new_rx_data_o),
        .tx_start_i    (tx_start),
        .tx_data_i     (tx_data),
        .tx_ready_o    (tx_ready_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_bits_o    (rsp_bits_o),
        .rsp_count_o   (rsp_count_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mon_b[$];
    int         mon_c[$];
    int         rsp_n = 0;
    int         rsp_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (new_rx_data_o) begin
                mon_b.push_back(rx_data_o);
                mon_c.push_back(cyc);
            end
            if (rsp_valid_o) begin
                rsp_n   = rsp_n + 1;
                rsp_cyc = cyc;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int base_n, base_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic [7:0] cmd, input logic [15:0] cnt, input logic [MB-1:0] bits,
                             output int a);
        int k;
        k = 0;
        @(posedge clk); #1;
        while (!req_ready_o && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_before_req", 64'(req_ready_o), 64'd1);
        base_n    = rsp_n;
        base_b    = mon_b.size();
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_count = cnt;
        req_bits  = bits;
        @(posedge clk); #1;
        req_valid = 1'b0;
        a = cyc;
        chk("ready_drop", 64'(req_ready_o), 64'd0);
    endtask

    task automatic wait_rsp(input int budget);
        int k;
        k = 0;
        while (rsp_n == base_n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_seen", 64'(rsp_n != base_n), 64'd1);
        repeat (6) @(negedge clk);
        chk("rsp_once", 64'(rsp_n - base_n), 64'd1);
    endtask

    task automatic send_reply(input logic [7:0] b);
        int  k;
        logic ok;
        k  = 0;
        ok = 1'b1;
        while (!tx_ready_o && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        tx_start = 1'b1;
        tx_data  = b;
        @(posedge clk); #1;
        tx_start = 1'b0;
        if (tx_ready_o) ok = 1'b0;
        repeat (BUSY - 1) begin
            @(posedge clk); #1;
            if (tx_ready_o) ok = 1'b0;
        end
        @(posedge clk); #1;
        if (!tx_ready_o) ok = 1'b0;
        chk("tx_busy_window", 64'(ok), 64'd1);
    endtask

    typedef struct {
        logic [7:0]    cmd;
        logic [15:0]   count;
        logic [MB-1:0] bits;
        int            n;
        logic [95:0]   exp;
        logic          err;
    } vec_t;

    vec_t vt[9];

    initial begin
        int a, n, nb, nr, k;
        logic [7:0] eb;

        vt[0] = '{cmd:8'h72, count:16'd0,      bits:8'h00, n:1,  exp:96'h72, err:1'b0};
        vt[1] = '{cmd:8'h73, count:16'd3,      bits:8'h05, n:6,  exp:96'h73_00_03_31_30_31, err:1'b0};
        vt[2] = '{cmd:8'h65, count:16'h1234,   bits:8'h00, n:3,  exp:96'h65_12_34, err:1'b0};
        vt[3] = '{cmd:8'h69, count:16'd0,      bits:8'h00, n:0,  exp:96'h0, err:1'b1};
        vt[4] = '{cmd:8'h73, count:16'd9,      bits:8'hFF, n:0,  exp:96'h0, err:1'b1};
        vt[5] = '{cmd:8'h69, count:16'd8,      bits:8'hA5, n:11, exp:96'h69_00_08_31_30_31_30_30_31_30_31, err:1'b0};
        vt[6] = '{cmd:8'h7A, count:16'd0,      bits:8'h00, n:1,  exp:96'h7A, err:1'b1};
        vt[7] = '{cmd:8'h70, count:16'd0,      bits:8'h00, n:1,  exp:96'h70, err:1'b0};
        vt[8] = '{cmd:8'h67, count:16'd0,      bits:8'h00, n:0,  exp:96'h0, err:1'b1};

        rst = 1'b1; req_valid = 1'b0; req_cmd = 8'd0; req_count = 16'd0; req_bits = '0;
        tx_start = 1'b0; tx_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_tx_ready", 64'(tx_ready_o), 64'd1);
        chk("rst_rx", 64'({new_rx_data_o, rx_data_o}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_count_o, rsp_bits_o}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start_req(vt[i].cmd, vt[i].count, vt[i].bits, a);
            wait_rsp(300);
            n = mon_b.size() - base_b;
            chk($sformatf("v%0d_nbytes", i), 64'(n), 64'(vt[i].n));
            for (int j = 0; j < vt[i].n && j < n; j++) begin
                eb = vt[i].exp[8*(vt[i].n-1-j) +: 8];
                chk($sformatf("v%0d_byte%0d", i, j), 64'(mon_b[base_b+j]), 64'(eb));
                chk($sformatf("v%0d_pulse%0d_cyc", i, j), 64'(mon_c[base_b+j] - a), 64'((GAP+1)*j));
            end
            chk($sformatf("v%0d_rsp_cyc", i), 64'(rsp_cyc - a), 64'((GAP+1)*vt[i].n));
            chk($sformatf("v%0d_err", i), 64'(rsp_err_o), 64'(vt[i].err));
            chk($sformatf("v%0d_timeout", i), 64'(rsp_timeout_o), 64'd0);
        end

        // 'g' count 4, reply "1101"
        start_req(8'h67, 16'd4, '0, a);
        send_reply(8'h31); send_reply(8'h31); send_reply(8'h30); send_reply(8'h31);
        wait_rsp(300);
        chk("g4_bits", 64'(rsp_bits_o), 64'h0B);
        chk("g4_count", 64'(rsp_count_o), 64'd4);
        chk("g4_flags", 64'({rsp_err_o, rsp_timeout_o}), 64'd0);
        chk("g4_sent", 64'(mon_b.size() - base_b), 64'd3);

        // 'o' count 1 expects one char
        start_req(8'h6F, 16'd1, '0, a);
        send_reply(8'h31);
        wait_rsp(300);
        chk("o1_count", 64'(rsp_count_o), 64'd1);
        chk("o1_bits", 64'(rsp_bits_o), 64'h01);
        chk("o1_flags", 64'({rsp_err_o, rsp_timeout_o}), 64'd0);

        // 'o' count 5 expects four chars
        start_req(8'h6F, 16'd5, '0, a);
        send_reply(8'h31); send_reply(8'h30); send_reply(8'h30); send_reply(8'h31);
        wait_rsp(300);
        chk("o5_count", 64'(rsp_count_o), 64'd4);
        chk("o5_bits", 64'(rsp_bits_o), 64'h09);
        chk("o5_flags", 64'({rsp_err_o, rsp_timeout_o}), 64'd0);

        // 'g' count 2, reply "1x"
        start_req(8'h67, 16'd2, '0, a);
        send_reply(8'h31); send_reply(8'h78);
        wait_rsp(300);
        chk("g2x_count", 64'(rsp_count_o), 64'd2);
        chk("g2x_bits", 64'(rsp_bits_o), 64'h01);
        chk("g2x_err", 64'(rsp_err_o), 64'd1);
        chk("g2x_timeout", 64'(rsp_timeout_o), 64'd0);

        // tx_start held while busy must be ignored
        start_req(8'h67, 16'd2, '0, a);
        tx_start = 1'b1; tx_data = 8'h31;
        @(posedge clk); #1;
        tx_data = 8'h78;
        repeat (BUSY) @(posedge clk);
        #1;
        tx_start = 1'b0;
        send_reply(8'h31);
        wait_rsp(300);
        chk("busy_ign_count", 64'(rsp_count_o), 64'd2);
        chk("busy_ign_bits", 64'(rsp_bits_o), 64'h03);
        chk("busy_ign_err", 64'(rsp_err_o), 64'd0);

        // 'g' count 2 with a single reply char times out
        start_req(8'h67, 16'd2, '0, a);
        send_reply(8'h31);
        wait_rsp(400);
        chk("to_timeout", 64'(rsp_timeout_o), 64'd1);
        chk("to_count", 64'(rsp_count_o), 64'd1);
        chk("to_bits", 64'(rsp_bits_o), 64'h01);
        chk("to_cyc", 64'(rsp_cyc - a), 64'(3*(GAP+1) + TO + 1));

        // reset in the middle of an 's' payload
        start_req(8'h73, 16'd8, 8'hFF, a);
        k = 0;
        while ((mon_b.size() - base_b) < 5 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reached_payload", 64'((mon_b.size() - base_b) >= 5), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nb = mon_b.size();
        nr = rsp_n;
        chk("mid_rst_ready", 64'(req_ready_o), 64'd1);
        repeat (60) @(negedge clk);
        chk("mid_rst_no_bytes", 64'(mon_b.size() - nb), 64'd0);
        chk("mid_rst_no_rsp", 64'(rsp_n - nr), 64'd0);
        chk("mid_rst_no_rsp_since_req", 64'(rsp_n - base_n), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
